// File: rtl/virtual_host_if.sv
// Cast/merge handshake bundle between a virtual host (master) and the network (slave).
// Global flit-format parameters are defined here when no other file has defined them.
`ifndef DW
`define DW 16
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b11
`endif

interface virtual_host_if;
  logic [`DW-1:0] cast_data_o;
  logic           cast_valid_o;
  logic           cast_ready_i;
  logic [`DW-1:0] merge_data_i;
  logic           merge_valid_i;
  logic           merge_ready_o;

  modport master (
    output cast_data_o, cast_valid_o, merge_ready_o,
    input  cast_ready_i, merge_data_i, merge_valid_i
  );

  modport slave (
    input  cast_data_o, cast_valid_o, merge_ready_o,
    output cast_ready_i, merge_data_i, merge_valid_i
  );
endinterface

// File: rtl/virtual_host.sv
// Deadlock-test traffic endpoint: injects a deterministic packet stream on the cast port,
// sinks the merge port with optional periodic backpressure, and checks flit-type ordering.
`ifndef DW
`define DW 16
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b11
`endif

module virtual_host #(
  parameter int NUM_PKT         = 8,
  parameter int PKT_LEN         = 4,
  parameter int BASE            = 0,
  parameter int GAP             = 0,
  parameter int EXP_RX_FLITS    = 32,
  parameter int RX_STALL_PERIOD = 0,
  parameter int TIMEOUT         = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  virtual_host_if.master   net,
  output logic             tx_done,
  output logic             rx_done,
  output logic [15:0]      rx_flits,
  output logic [`DW-3:0]   rx_checksum,
  output logic             proto_err,
  output logic             deadlock
);
  localparam int PW = `DW - 2;

  typedef enum logic [1:0] {IDLE, SEND, GAP_WAIT, DONE} state_t;

  state_t        state, state_next;
  logic [15:0]   pkt_idx, flit_idx, gap_cnt;
  logic          cast_hs, merge_hs, last_flit, last_pkt, gap_over;
  logic [1:0]    flit_type, rx_type;
  logic [PW-1:0] payload;
  logic [15:0]   flits_next;
  logic          type_err, in_pkt, armed;
  logic [31:0]   wd_cnt;

  assign cast_hs   = net.cast_valid_o & net.cast_ready_i;
  assign merge_hs  = net.merge_valid_i & net.merge_ready_o;
  assign last_flit = (int'(flit_idx) == PKT_LEN - 1);
  assign last_pkt  = (int'(pkt_idx) == NUM_PKT - 1);
  assign gap_over  = (int'(gap_cnt) >= GAP - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = SEND;
      SEND: begin
        if (cast_hs && last_flit) begin
          if (last_pkt)      state_next = DONE;
          else if (GAP == 0) state_next = SEND;
          else               state_next = GAP_WAIT;
        end
      end
      GAP_WAIT: if (gap_over) state_next = SEND;
      DONE:     state_next = DONE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_idx  <= '0;
      flit_idx <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pkt_idx  <= '0;
            flit_idx <= '0;
          end
        end
        SEND: begin
          if (cast_hs) begin
            gap_cnt <= '0;
            if (last_flit) begin
              pkt_idx  <= pkt_idx + 16'd1;
              flit_idx <= '0;
            end else begin
              flit_idx <= flit_idx + 16'd1;
            end
          end
        end
        GAP_WAIT: gap_cnt <= gap_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  // Payload arithmetic is done at PW width so it wraps modulo 2^PW for free.
  assign flit_type        = (flit_idx == 16'd0) ? `HEAD : (last_flit ? `TAIL : `BODY);
  assign payload          = PW'(BASE) + PW'(pkt_idx) * PW'(PKT_LEN) + PW'(flit_idx);
  assign net.cast_valid_o = (state == SEND);
  assign net.cast_data_o  = (state == SEND) ? {flit_type, payload} : '0;
  assign tx_done          = (state == DONE);

  assign rx_type    = net.merge_data_i[`DW-1:`DW-2];
  assign flits_next = (rx_flits == 16'hFFFF) ? rx_flits : rx_flits + 16'd1;

  always_comb begin
    type_err = 1'b0;
    if (rx_type == `HEAD && in_pkt) type_err = 1'b1;
    if ((rx_type == `BODY || rx_type == `TAIL) && !in_pkt) type_err = 1'b1;
    if (rx_type != `HEAD && rx_type != `BODY && rx_type != `TAIL) type_err = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_flits    <= '0;
      rx_checksum <= '0;
      rx_done     <= 1'b0;
      proto_err   <= 1'b0;
      in_pkt      <= 1'b0;
    end else if (merge_hs) begin
      rx_flits    <= flits_next;
      rx_checksum <= rx_checksum + net.merge_data_i[`DW-3:0];
      if (int'(flits_next) >= EXP_RX_FLITS) rx_done <= 1'b1;
      if (type_err) proto_err <= 1'b1;
      if (rx_type == `HEAD)      in_pkt <= 1'b1;
      else if (rx_type == `TAIL) in_pkt <= 1'b0;
    end
  end

  generate
    if (RX_STALL_PERIOD == 0) begin : g_no_stall
      assign net.merge_ready_o = 1'b1;
    end else begin : g_stall
      logic [31:0] stall_cnt;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          stall_cnt <= '0;
        else if (stall_cnt == 32'(RX_STALL_PERIOD - 1))   stall_cnt <= '0;
        else                                              stall_cnt <= stall_cnt + 32'd1;
      end
      assign net.merge_ready_o = (stall_cnt != 32'd0);
    end
  endgenerate

  // Watchdog arms on the accepted start and disarms once both directions have finished.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed    <= 1'b0;
      wd_cnt   <= '0;
      deadlock <= 1'b0;
    end else begin
      if (state == IDLE && start)  armed <= 1'b1;
      else if (tx_done && rx_done) armed <= 1'b0;
      if (armed && !deadlock) begin
        if (cast_hs || merge_hs) begin
          wd_cnt <= '0;
        end else begin
          wd_cnt <= wd_cnt + 32'd1;
          if (wd_cnt + 32'd1 == 32'(TIMEOUT)) deadlock <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/virtual_host.md
# virtual_host

Traffic endpoint that drives the network's cast port and terminates its merge port, for deadlock verification of the whole network. A start pulse makes it inject a fixed, deterministic sequence of HEAD/BODY/TAIL packets into a caster's cast input. It then sinks merged flits with optional periodic backpressure and checks flit-type ordering. A no-progress watchdog raises a sticky deadlock flag. Flit format uses the global params: type in [`DW-1:`DW-2] (`HEAD/`BODY/`TAIL), payload in [`DW-3:0].

## Interface
- NUM_PKT, 8: packets injected per start; must be ≥1.
- PKT_LEN, 4: flits per packet, including HEAD and TAIL; must be ≥2.
- BASE, 0: payload base value.
- GAP, 0: idle cycles between a TAIL handshake and the next HEAD.
- EXP_RX_FLITS, 32: number of merge flits that completes reception.
- RX_STALL_PERIOD, 0: 0 means merge_ready_o is always 1. N>0 means merge_ready_o is 0 one cycle in every N.
- TIMEOUT, 1024: watchdog limit in cycles; must be ≥1.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a run.
- cast_data_o  out  `DW  injected flit.
- cast_valid_o  out  1  flit valid.
- cast_ready_i  in  1  network accepts the flit.
- merge_data_i  in  `DW  merged flit from the network.
- merge_valid_i  in  1  merged flit valid.
- merge_ready_o  out  1  host accepts the merged flit.
- tx_done  out  1  all packets sent; sticky.
- rx_done  out  1  EXP_RX_FLITS flits received; sticky.
- rx_flits  out  16  count of accepted merge flits.
- rx_checksum  out  `DW-2  modular sum of accepted payloads.
- proto_err  out  1  flit-type ordering violation; sticky.
- deadlock  out  1  watchdog expired; sticky.

## Operation
- Transmit FSM states: IDLE, SEND, GAP_WAIT, DONE.
- IDLE:
  - start=1 → SEND; the packet index p and flit index k clear to 0.
  - start in any other state is ignored.
- SEND: cast_valid_o=1.
  - Type: k=0 → `HEAD; k=PKT_LEN-1 → `TAIL; otherwise `BODY.
  - Payload: (BASE + p·PKT_LEN + k) mod 2^(`DW-2).
  - On handshake (valid & ready), k increments.
  - After a TAIL handshake: p increments and k=0. If p was NUM_PKT-1 → DONE. Otherwise → GAP_WAIT, or straight back to SEND when GAP=0.
- GAP_WAIT: cast_valid_o=0 for GAP cycles, then → SEND.
- DONE: cast_valid_o=0 and tx_done=1. Stays here until reset.
- Receive path:
  - Accept when merge_valid_i & merge_ready_o. Each accept increments rx_flits (saturating at 0xFFFF) and adds the payload into rx_checksum, wrapping.
  - Once rx_flits reaches EXP_RX_FLITS, rx_done=1. Later flits are still accepted and still counted.
- Protocol checker: one bit, in_pkt.
  - `HEAD accepted while in_pkt=1 → error.
  - `BODY or `TAIL accepted while in_pkt=0 → error.
  - Any type code outside `HEAD/`BODY/`TAIL → error.
  - `HEAD sets in_pkt; `TAIL clears it.
  - An error sets proto_err, and in_pkt is still updated by the flit's type.
- Backpressure: a free-running counter wraps at RX_STALL_PERIOD-1. merge_ready_o=0 while the counter is 0, and 1 otherwise.
- Watchdog: armed from the first start until tx_done & rx_done are both 1.
  - While armed, the count increments on every cycle with no handshake on either port.
  - Any handshake clears the count.
  - When the count reaches TIMEOUT, deadlock=1 and the count stops.

## Timing
- Reset (asynchronous): all outputs are 0 immediately, except merge_ready_o, which is 1 when RX_STALL_PERIOD=0. FSM → IDLE; counters, in_pkt, watchdog and sticky flags clear. A reset during a run abandons it; a new start is needed.
- A start pulse in cycle t gives cast_valid_o=1 from cycle t+1.
- While cast_valid_o=1 and cast_ready_i=0, cast_data_o and cast_valid_o hold stable.
- With cast_ready_i held 1 and GAP=0, flits go out back-to-back: one per cycle, NUM_PKT·PKT_LEN cycles in total.
- tx_done rises in the cycle after the final TAIL handshake.
- rx_flits, rx_checksum, proto_err and rx_done all update in the cycle after the accepting edge.
- Transmit and receive run independently. Handshakes on both ports in the same cycle are both processed.
- The stall counter runs from reset, regardless of start.

## Test plan
1. NUM_PKT=2, PKT_LEN=3, BASE=10, cast_ready_i=1, start at cycle 5 → flits (H,10)(B,11)(T,12)(H,13)(B,14)(T,15) on cycles 6–11; tx_done=1 at cycle 12.
2. Same setup, cast_ready_i low on cycles 7–9 → (B,11) held stable until accepted at cycle 10; all 6 flits still sent, in order.
3. Feed merge flits H5,B6,T7, EXP_RX_FLITS=3, RX_STALL_PERIOD=0 → rx_flits=3, rx_checksum=18, rx_done=1, proto_err=0.
4. Feed merge flits H,H, then B,T with no HEAD before them → proto_err=1 after the second flit and stays 1.
5. TIMEOUT=16, start, cast_ready_i held 0 → deadlock=1 16 cycles after start+1; tx_done=0.
6. Assert rst mid-packet → all outputs return to reset values immediately. A new start restarts from (H,BASE).
